// File: rtl/scroll_pkg.sv
// Shared types and constants for the scroll scheduler: FSM state encoding,
// digit/message widths and the blank digit code.
package scroll_pkg;

    localparam int unsigned DIGIT_W = 4;
    localparam int unsigned MSG_W   = 12;

    localparam logic [DIGIT_W-1:0] BLANK = 4'hF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        GAP  = 2'd2,
        SHOW = 2'd3
    } state_e;

    // Digit idx 0 is the leftmost segment, held in the message MSBs.
    function automatic logic [DIGIT_W-1:0] msg_digit(input logic [MSG_W-1:0] msg,
                                                     input logic [1:0]       idx);
        logic [DIGIT_W-1:0] d;
        case (idx)
            2'd0:    d = msg[MSG_W-1 -: DIGIT_W];
            2'd1:    d = msg[MSG_W-DIGIT_W-1 -: DIGIT_W];
            2'd2:    d = msg[DIGIT_W-1:0];
            default: d = BLANK;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/msg_fifo.sv
// Message FIFO: power-of-2 depth, registered occupancy count, synchronous clear.
// A push and pop in the same cycle leave the count unchanged.
module msg_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned MSG_W = 12,
    localparam int unsigned AW   = $clog2(DEPTH),
    localparam int unsigned CntW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             push,
    input  logic             pop,
    input  logic [MSG_W-1:0] din,
    output logic [MSG_W-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [CntW-1:0]  count
);

    logic [MSG_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             do_push, do_pop;

    assign full  = (count_q == CntW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign dout  = mem_q[rd_ptr_q];

    always_comb begin
        do_push  = push && !full && !clr;
        do_pop   = pop && !empty && !clr;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; validity is tracked by the pointers alone.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/scroll_sched.sv
// Scroll scheduler: round-robin intake of two message sources into a FIFO and
// a LOAD/GAP/SHOW sequencer that feeds three digits per message to the scroller.
module scroll_sched
    import scroll_pkg::*;
#(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned IDLE_TICKS = 16,
    parameter int unsigned PASS_TICKS = 7,
    localparam int unsigned CntW      = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tick,
    input  logic               req_a,
    input  logic               req_b,
    input  logic [MSG_W-1:0]   msg_a,
    input  logic [MSG_W-1:0]   msg_b,
    input  logic               flush,
    output logic               gnt_a,
    output logic               gnt_b,
    output logic               o_rd,
    output logic [DIGIT_W-1:0] o_dec,
    output logic               o_clean,
    output logic               busy,
    output logic               fifo_full,
    output logic               fifo_empty,
    output logic [CntW-1:0]    msg_cnt
);

    localparam int unsigned IdleW = $clog2(IDLE_TICKS + 1);
    localparam logic [IdleW-1:0] IdleMax  = IdleW'(IDLE_TICKS);
    localparam logic [IdleW-1:0] IdleLast = IdleW'(IDLE_TICKS - 1);
    localparam logic [2:0]       PassLast = 3'(PASS_TICKS - 1);

    state_e             state_q, state_d;
    logic [1:0]         sub_q, sub_d;
    logic [2:0]         tick_cnt_q, tick_cnt_d;
    logic [IdleW-1:0]   idle_cnt_q, idle_cnt_d;
    logic [MSG_W-1:0]   msg_q, msg_d;
    logic [DIGIT_W-1:0] dec_q, dec_d;
    logic               clean_q, clean_d;
    logic               prio_b_q, prio_b_d;

    logic               can_gnt;
    logic               push, pop;
    logic [MSG_W-1:0]   push_data;
    logic [MSG_W-1:0]   fifo_dout;

    msg_fifo #(
        .DEPTH (DEPTH),
        .MSG_W (MSG_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clr   (flush),
        .push  (push),
        .pop   (pop),
        .din   (push_data),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (msg_cnt)
    );

    // prio_b_q set means B wins the next tie; cleared by reset so A starts ahead.
    always_comb begin
        can_gnt   = rst && !fifo_full && !flush;
        gnt_a     = can_gnt && req_a && (!req_b || !prio_b_q);
        gnt_b     = can_gnt && req_b && (!req_a || prio_b_q);
        push      = gnt_a || gnt_b;
        push_data = gnt_a ? msg_a : msg_b;
        prio_b_d  = prio_b_q;
        if (gnt_a) begin
            prio_b_d = 1'b1;
        end else if (gnt_b) begin
            prio_b_d = 1'b0;
        end
    end

    always_comb begin
        state_d    = state_q;
        sub_d      = sub_q;
        tick_cnt_d = tick_cnt_q;
        idle_cnt_d = idle_cnt_q;
        msg_d      = msg_q;
        pop        = 1'b0;
        if (flush) begin
            state_d    = IDLE;
            sub_d      = '0;
            tick_cnt_d = '0;
            idle_cnt_d = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (!fifo_empty) begin
                        state_d    = LOAD;
                        pop        = 1'b1;
                        msg_d      = fifo_dout;
                        sub_d      = '0;
                        idle_cnt_d = '0;
                    end else if (tick && idle_cnt_q != IdleMax) begin
                        idle_cnt_d = idle_cnt_q + 1'b1;
                    end
                end
                LOAD: begin
                    if (sub_q == 2'd2) begin
                        state_d = GAP;
                        sub_d   = '0;
                    end else begin
                        sub_d = sub_q + 1'b1;
                    end
                end
                GAP: begin
                    // A tick on this transition edge is deliberately not counted.
                    if (sub_q == 2'd1) begin
                        state_d    = SHOW;
                        sub_d      = '0;
                        tick_cnt_d = '0;
                    end else begin
                        sub_d = sub_q + 1'b1;
                    end
                end
                SHOW: begin
                    if (tick) begin
                        if (tick_cnt_q == PassLast) begin
                            tick_cnt_d = '0;
                            if (!fifo_empty) begin
                                state_d = LOAD;
                                pop     = 1'b1;
                                msg_d   = fifo_dout;
                                sub_d   = '0;
                            end else begin
                                state_d = IDLE;
                            end
                        end else begin
                            tick_cnt_d = tick_cnt_q + 1'b1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        dec_d   = (!flush && state_q == LOAD) ? msg_digit(msg_q, sub_q) : BLANK;
        clean_d = flush ||
                  (state_q == IDLE && fifo_empty && tick && idle_cnt_q == IdleLast);
    end

    assign o_rd    = (state_q == LOAD);
    assign busy    = (state_q != IDLE);
    assign o_dec   = dec_q;
    assign o_clean = clean_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            sub_q      <= '0;
            tick_cnt_q <= '0;
            idle_cnt_q <= '0;
            msg_q      <= '0;
            dec_q      <= BLANK;
            clean_q    <= 1'b0;
            prio_b_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            sub_q      <= sub_d;
            tick_cnt_q <= tick_cnt_d;
            idle_cnt_q <= idle_cnt_d;
            msg_q      <= msg_d;
            dec_q      <= dec_d;
            clean_q    <= clean_d;
            prio_b_q   <= prio_b_d;
        end
    end

endmodule
